pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed single-entry stage registers between IF/ID/EX/MEM/WB.
- Multi-entry, width-generic elastic buffer using the pipeline's valid/allow_in handshake.
- Adds synchronous flush for EX-side redirect and a selectable registered-ready mode.
- First user: IF->ID instruction buffer (DEPTH=4); other stage boundaries later, with DEPTH=1.

Parameters:
- WIDTH, 64, bit width of the stage bus carried per entry.
- DEPTH, 2, number of entries; legal range 1..16; need not be a power of two.
- REG_READY, 0
  - 0: allow_in depends combinationally on next_allow_in when full.
  - 1: allow_in = !full only.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all held entries (branch/jump redirect).
- in_valid  in  1  upstream has a valid bus this cycle.
- in_bus  in  WIDTH  upstream stage bus.
- allow_in  out  1  this block accepts in_bus this cycle.
- out_valid  out  1  head entry valid toward downstream.
- out_bus  out  WIDTH  head entry; all-zero when out_valid=0.
- next_allow_in  in  1  downstream accepts this cycle.
- count  out  CW  occupancy, 0..DEPTH; CW = clog2(DEPTH+1).

Behaviour:
- Reset is synchronous and active-high on rst, clocked by clk.
- On reset:
  - count=0, out_valid=0, out_bus=0, allow_in=1.
  - Read/write pointers=0; storage contents are don't-care.
- Definitions:
  - push = in_valid & allow_in & !flush
  - pop = out_valid & next_allow_in
  - full = (count==DEPTH); empty = (count==0)
- allow_in:
  - REG_READY=0: allow_in = !full | next_allow_in.
  - REG_READY=1: allow_in = !full.
  - allow_in is forced to 1 during rst and flush; any push in those cycles is discarded.
- Storage is a circular buffer:
  - Write pointer advances on push; read pointer advances on pop.
  - Each pointer wraps from DEPTH-1 to 0, including non-power-of-two DEPTH.
- Count update:
  - count += push - pop.
  - Simultaneous push and pop when full is legal (REG_READY=0): count stays DEPTH.
  - Simultaneous push and pop when empty is impossible without bypass, since out_valid=0.
- Latency and throughput:
  - A push into an empty buffer is visible on out_valid/out_bus the next cycle (1-cycle latency).
  - Sustained 1 transfer/cycle when DEPTH>=2, or when DEPTH=1 with REG_READY=0.
  - DEPTH=1 with REG_READY=1 gives half throughput; this combination is documented as legal.
- Ordering: strict FIFO; no entry is dropped or duplicated except by flush or rst.
- out_valid = !empty. out_bus = storage[rd_ptr] when out_valid, else 0.
- Flush:
  - In the flush cycle, count, pointers and out_valid clear at the clock edge; out_valid=0 next cycle.
  - Any pop in the flush cycle still completes downstream, since downstream sampled it.
  - Flush has priority over push.
- Rst has priority over flush.
- No state machine beyond the occupancy counter; the buffer never stalls itself.
- An assertion (simulation only) fires on push when full with allow_in=0. This cannot occur by construction.

Optional Feature:
- Macro: PIPE_BYPASS_EN.
- When defined:
  - If empty & in_valid & !flush & !rst, then out_valid=1 and out_bus=in_bus combinationally.
  - If next_allow_in is also 1, the beat passes with zero latency and is not written to storage.
  - If next_allow_in=0, the beat is written normally (count becomes 1).
- When undefined: the minimum latency is always 1 cycle and out_valid depends only on registered state.

Test Plan:
- DEPTH=4, REG_READY=0, next_allow_in=1; push 0x11,0x22,0x33 on consecutive cycles -> out_bus shows 0x11,0x22,0x33 one cycle after each push; count never exceeds 1.
- DEPTH=4; next_allow_in=0; push 5 beats (0xA0..0xA4) -> count reaches 4; allow_in=0 while full; 0xA4 is held upstream. Then next_allow_in=1 -> output order A0,A1,A2,A3,A4.
- DEPTH=3 (non-power-of-two); run 10 push/pop cycles with random stalls -> correct order across pointer wrap, and count matches a reference model each cycle.
- count=3 with 0xB0..0xB2 held; assert flush with in_valid=1 carrying 0xC0 -> next cycle count=0, out_valid=0, and 0xC0 never appears at the output.
- DEPTH=1, REG_READY=0 vs REG_READY=1; continuous valid input with next_allow_in=1 -> 10 beats in 10 cycles vs 10 beats in 20 cycles.
- Assert rst mid-stream with count=2 -> next cycle count=0, out_valid=0, out_bus=0, allow_in=1. With PIPE_BYPASS_EN, a beat 0x5A into an empty buffer with next_allow_in=1 -> out_valid=1 and out_bus=0x5A in the same cycle; count stays 0.

Source files
------------

// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for pipe_stage_buf: upstream valid/bus/allow_in and downstream valid/bus/next_allow_in.
// The slave modport is the buffer's view; the master modport is the surrounding pipeline's view.
interface pipe_stage_buf_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] in_bus;
  logic             allow_in;
  logic             out_valid;
  logic [WIDTH-1:0] out_bus;
  logic             next_allow_in;

  modport slave (
    input  in_valid,
    input  in_bus,
    input  next_allow_in,
    output allow_in,
    output out_valid,
    output out_bus
  );

  modport master (
    output in_valid,
    output in_bus,
    output next_allow_in,
    input  allow_in,
    input  out_valid,
    input  out_bus
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Multi-entry elastic stage buffer (circular FIFO) using the valid/allow_in handshake, with flush.
// Optional zero-latency pass-through when empty is enabled by defining PIPE_BYPASS_EN.
module pipe_stage_buf #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 2,
  parameter bit REG_READY = 1'b0,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  pipe_stage_buf_if.slave bus,
  output logic [CW-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]    count_reg, count_next;

  logic full, empty;
  logic push, pop;
  logic push_store, pop_store;
  logic bypass;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  always_comb begin
    if (rst || flush) begin
      bus.allow_in = 1'b1;
    end else if (REG_READY) begin
      bus.allow_in = !full;
    end else begin
      bus.allow_in = !full || bus.next_allow_in;
    end
  end

`ifdef PIPE_BYPASS_EN
  assign bypass = empty && bus.in_valid && !flush && !rst;
`else
  assign bypass = 1'b0;
`endif

  assign bus.out_valid = !empty || bypass;

  always_comb begin
    if (!empty) begin
      bus.out_bus = mem_reg[rd_ptr_reg];
    end else if (bypass) begin
      bus.out_bus = bus.in_bus;
    end else begin
      bus.out_bus = '0;
    end
  end

  assign push = bus.in_valid && bus.allow_in && !flush && !rst;
  assign pop  = bus.out_valid && bus.next_allow_in;

  // A bypassed beat taken downstream this cycle never touches storage.
  assign push_store = push && !(bypass && bus.next_allow_in);
  assign pop_store  = pop && !empty;

  always_comb begin
    wr_ptr_next = push_store ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = pop_store  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    count_next  = count_reg;
    case ({push_store, pop_store})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_store) begin
      mem_reg[wr_ptr_reg] <= bus.in_bus;
    end
  end

  assign count = count_reg;

`ifndef SYNTHESIS
  // Storing into a full buffer without a simultaneous pop would overwrite the head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_store && full && !pop_store));
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: DEPTH=4/3/1 instances, handshake, wrap, flush, reset and throughput.
module tb_pipe_stage_buf;
  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  pipe_stage_buf_if #(.WIDTH(8)) i4 ();
  pipe_stage_buf_if #(.WIDTH(8)) i3 ();
  pipe_stage_buf_if #(.WIDTH(8)) i1a ();
  pipe_stage_buf_if #(.WIDTH(8)) i1b ();

  logic [2:0] cnt4;
  logic [1:0] cnt3;
  logic [0:0] cnt1a;
  logic [0:0] cnt1b;

  pipe_stage_buf #(.WIDTH(8), .DEPTH(4), .REG_READY(1'b0)) u4 (
    .clk(clk), .rst(rst), .flush(flush), .bus(i4), .count(cnt4));
  pipe_stage_buf #(.WIDTH(8), .DEPTH(3), .REG_READY(1'b0)) u3 (
    .clk(clk), .rst(rst), .flush(flush), .bus(i3), .count(cnt3));
  pipe_stage_buf #(.WIDTH(8), .DEPTH(1), .REG_READY(1'b0)) u1a (
    .clk(clk), .rst(rst), .flush(flush), .bus(i1a), .count(cnt1a));
  pipe_stage_buf #(.WIDTH(8), .DEPTH(1), .REG_READY(1'b1)) u1b (
    .clk(clk), .rst(rst), .flush(flush), .bus(i1b), .count(cnt1b));

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] ivp;
  logic [15:0] naip;
  logic [7:0]  q[$];
  logic [7:0]  seq;
  logic [7:0]  exp_bus;
  logic        exp_allow;
  logic        acc, pp;
  int          na, nb, rcv_a, rcv_b;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    i4.in_valid = 0;  i4.in_bus = 0;  i4.next_allow_in = 0;
    i3.in_valid = 0;  i3.in_bus = 0;  i3.next_allow_in = 0;
    i1a.in_valid = 0; i1a.in_bus = 0; i1a.next_allow_in = 0;
    i1b.in_valid = 0; i1b.in_bus = 0; i1b.next_allow_in = 0;
    tick();
    tick();
    chk("rst_allow_during", i4.allow_in, 1);
    rst = 1'b0;
    #1;
    chk("rst_count", cnt4, 0);
    chk("rst_ovalid", i4.out_valid, 0);
    chk("rst_obus", i4.out_bus, 0);
    chk("rst_allow", i4.allow_in, 1);

    // Streaming with downstream always ready: 1-cycle latency, count stays at 1.
    i4.next_allow_in = 1;
    i4.in_valid = 1; i4.in_bus = 8'h11; #1;
    chk("t1_c0_ovalid", i4.out_valid, 0);
    chk("t1_c0_allow", i4.allow_in, 1);
    tick();
    i4.in_bus = 8'h22; #1;
    chk("t1_c1_obus", i4.out_bus, 8'h11);
    chk("t1_c1_count", cnt4, 1);
    tick();
    i4.in_bus = 8'h33; #1;
    chk("t1_c2_obus", i4.out_bus, 8'h22);
    chk("t1_c2_count", cnt4, 1);
    tick();
    i4.in_valid = 0; #1;
    chk("t1_c3_obus", i4.out_bus, 8'h33);
    chk("t1_c3_count", cnt4, 1);
    tick();
    chk("t1_c4_ovalid", i4.out_valid, 0);
    chk("t1_c4_count", cnt4, 0);
    $display("t1 stream 11,22,33 done");

    // Fill to DEPTH with downstream stalled, then drain in order.
    i4.next_allow_in = 0;
    for (int k = 0; k < 4; k++) begin
      i4.in_valid = 1; i4.in_bus = 8'hA0 + 8'(k); #1;
      chk("t2_fill_count", cnt4, 32'(k));
      tick();
    end
    i4.in_bus = 8'hA4; #1;
    chk("t2_full_allow", i4.allow_in, 0);
    chk("t2_full_count", cnt4, 4);
    chk("t2_full_head", i4.out_bus, 8'hA0);
    tick();
    chk("t2_hold_count", cnt4, 4);
    chk("t2_hold_allow", i4.allow_in, 0);
    i4.next_allow_in = 1; #1;
    chk("t2_passthru_allow", i4.allow_in, 1);
    chk("t2_head_a0", i4.out_bus, 8'hA0);
    tick();
    i4.in_valid = 0;
    for (int k = 1; k < 5; k++) begin
      #1;
      chk("t2_drain_obus", i4.out_bus, 8'hA0 + 8'(k));
      chk("t2_drain_count", cnt4, 32'(5 - k));
      tick();
    end
    chk("t2_empty", i4.out_valid, 0);
    $display("t2 fill/drain A0..A4 done");

    // Flush with three held entries and a concurrent push of C0.
    i4.next_allow_in = 0;
    for (int k = 0; k < 3; k++) begin
      i4.in_valid = 1; i4.in_bus = 8'hB0 + 8'(k);
      tick();
    end
    i4.in_bus = 8'hC0; flush = 1; #1;
    chk("t4_pre_count", cnt4, 3);
    chk("t4_flush_allow", i4.allow_in, 1);
    tick();
    flush = 0; i4.in_valid = 0; i4.next_allow_in = 1; #1;
    chk("t4_count", cnt4, 0);
    chk("t4_ovalid", i4.out_valid, 0);
    chk("t4_obus", i4.out_bus, 0);
    tick();
    chk("t4_no_c0", i4.out_valid, 0);
    i4.in_valid = 1; i4.in_bus = 8'hD0;
    tick();
    i4.in_valid = 0; #1;
    chk("t4_after_obus", i4.out_bus, 8'hD0);
    chk("t4_after_count", cnt4, 1);
    tick();
    chk("t4_after_empty", i4.out_valid, 0);
    $display("t4 flush done");

    // Flush while full and stalled: allow_in is still forced high.
    i4.next_allow_in = 0;
    for (int k = 0; k < 4; k++) begin
      i4.in_valid = 1; i4.in_bus = 8'hF0 + 8'(k);
      tick();
    end
    i4.in_bus = 8'hF4; flush = 1; #1;
    chk("t4b_full_count", cnt4, 4);
    chk("t4b_flush_allow", i4.allow_in, 1);
    tick();
    flush = 0; i4.in_valid = 0; #1;
    chk("t4b_count", cnt4, 0);

    // DEPTH=3 with a stall pattern, checked against a queue model.
    ivp  = 16'b1101_1110_0111_1011;
    naip = 16'b1111_0101_1000_0100;
    seq  = 8'h30;
    for (int c = 0; c < 16; c++) begin
      i3.in_valid = ivp[c]; i3.in_bus = seq; i3.next_allow_in = naip[c]; #1;
      exp_bus   = (q.size() != 0) ? q[0] : 8'h00;
      exp_allow = (q.size() < 3) || naip[c];
      chk("t3_count", cnt3, 32'(q.size()));
      chk("t3_ovalid", i3.out_valid, 32'(q.size() != 0));
      chk("t3_obus", i3.out_bus, exp_bus);
      chk("t3_allow", i3.allow_in, exp_allow);
      acc = ivp[c] && exp_allow;
      pp  = (q.size() != 0) && naip[c];
      $display("t3 cyc=%0d push=%0d pop=%0d count=%0d", c, acc, pp, q.size());
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(seq);
        seq++;
      end
      tick();
    end
    i3.in_valid = 0; i3.next_allow_in = 1;
    tick(); tick(); tick(); tick();
    chk("t3_drained", i3.out_valid, 0);

    // DEPTH=1 throughput: REG_READY=0 sustains one beat per cycle, REG_READY=1 one per two.
    na = 0; nb = 0; rcv_a = 0; rcv_b = 0;
    i1a.in_valid = 1; i1a.next_allow_in = 1;
    i1b.in_valid = 1; i1b.next_allow_in = 1;
    for (int c = 0; c <= 20; c++) begin
      i1a.in_bus = 8'(na); i1b.in_bus = 8'(nb); #1;
      if (i1a.out_valid) begin
        chk("t5a_data", i1a.out_bus, 32'(rcv_a));
        $display("t5 r0 cyc=%0d beat=%0d", c, rcv_a);
        rcv_a++;
      end
      if (i1b.out_valid) begin
        chk("t5b_data", i1b.out_bus, 32'(rcv_b));
        $display("t5 r1 cyc=%0d beat=%0d", c, rcv_b);
        rcv_b++;
      end
      if (c == 10) begin
        chk("t5a_beats10", 32'(rcv_a), 10);
        chk("t5b_beats10", 32'(rcv_b), 5);
      end
      if (c == 20) chk("t5b_beats20", 32'(rcv_b), 10);
      if (i1a.allow_in) na++;
      if (i1b.allow_in) nb++;
      tick();
    end
    i1a.in_valid = 0; i1b.in_valid = 0;
    tick(); tick();

    // Reset mid-stream with two entries held.
    i4.next_allow_in = 0;
    i4.in_valid = 1; i4.in_bus = 8'hE0; tick();
    i4.in_bus = 8'hE1; tick();
    i4.in_bus = 8'hE2; #1;
    chk("t6_pre_count", cnt4, 2);
    rst = 1; #1;
    chk("t6_rst_allow", i4.allow_in, 1);
    tick();
    rst = 0; i4.in_valid = 0; #1;
    chk("t6_count", cnt4, 0);
    chk("t6_ovalid", i4.out_valid, 0);
    chk("t6_obus", i4.out_bus, 0);
    chk("t6_allow", i4.allow_in, 1);
    $display("t6 reset mid-stream done");

`ifdef PIPE_BYPASS_EN
    i4.next_allow_in = 1; i4.in_valid = 1; i4.in_bus = 8'h5A; #1;
    chk("byp_ovalid", i4.out_valid, 1);
    chk("byp_obus", i4.out_bus, 8'h5A);
    tick();
    i4.in_valid = 0; #1;
    chk("byp_count", cnt4, 0);
    chk("byp_after", i4.out_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
